// File: rtl/mem_fill_responder.sv
// mem_fill_responder
// Shared backing-store responder for an I-cache and a D-cache. In IDLE it
// accepts one request, then either streams a full cache line (WORDS 16-bit
// reads, one per cycle) back to the owning cache, or performs a single
// write-through for the D-cache. Read data returns LATENCY cycles after
// each issue: one cycle from the backing store plus LATENCY-1 pipeline
// stages.
//
// Ports
//   clk, rst                     clock, async active-high reset
//   i_rd_req, i_addr             I-cache line-fill request / byte address
//   i_grant, i_data,
//   i_data_valid, i_done         I-cache ownership, fill word, done pulse
//   d_rd_req, d_wr_req,
//   d_addr, d_wdata              D-cache fill / write-through request
//   d_grant, d_data,
//   d_data_valid, d_done         D-cache ownership, fill word, done pulse
//   mem_en, mem_wr, mem_addr,
//   mem_wdata, mem_rdata         backing-store port (rdata 1 cycle after read)
//
// state  | meaning
// IDLE   | no owner; the only state that accepts a request
// DFILL  | D-cache line fill: issuing reads and draining the data pipeline
// IFILL  | I-cache line fill: issuing reads and draining the data pipeline
// DWRITE | D-cache write-through: write cycle, then d_done cycle
module mem_fill_responder #(
    parameter int LATENCY = 4,
    parameter int WORDS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd_req,
    input  logic [15:0] i_addr,
    output logic        i_grant,
    output logic [15:0] i_data,
    output logic        i_data_valid,
    output logic        i_done,
    input  logic        d_rd_req,
    input  logic        d_wr_req,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_grant,
    output logic [15:0] d_data,
    output logic        d_data_valid,
    output logic        d_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);
    localparam int              CW        = $clog2(WORDS) + 1;
    localparam logic [15:0]     LINE_MASK = ~16'(2 * WORDS - 1);
    localparam logic [CW-1:0]   NUM_WORDS = CW'(WORDS);
    localparam logic [CW-1:0]   LAST_IDX  = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, DFILL, IFILL, DWRITE} state_t;

    state_t        state, state_nxt;
    logic          last_was_d;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [CW-1:0] issue_cnt;
    logic          wr_phase;
    logic [LATENCY-1:0] vld_pipe;
    logic [LATENCY-1:0] last_pipe;
    logic [15:0]   pipe_data;

    logic d_pend, i_pend;
    logic accept_d, accept_i;
    logic filling, issuing, issue_last, wr_cycle;
    logic pipe_vld, pipe_last;
    logic [15:0] fill_out;

    assign d_pend     = d_rd_req | d_wr_req;
    assign i_pend     = i_rd_req;
    assign filling    = (state == DFILL) || (state == IFILL);
    assign issuing    = filling && (issue_cnt != NUM_WORDS);
    assign issue_last = issuing && (issue_cnt == LAST_IDX);
    assign wr_cycle   = (state == DWRITE) && !wr_phase;
    assign pipe_vld   = vld_pipe[LATENCY-1];
    assign pipe_last  = last_pipe[LATENCY-1];

    always_comb begin
        state_nxt = state;
        accept_d  = 1'b0;
        accept_i  = 1'b0;
        case (state)
            IDLE: begin
                // On contention the side that was not served last wins.
                if (d_pend && (!i_pend || !last_was_d)) begin
                    accept_d  = 1'b1;
                    state_nxt = d_wr_req ? DWRITE : DFILL;
                end else if (i_pend) begin
                    accept_i  = 1'b1;
                    state_nxt = IFILL;
                end
            end
            DFILL, IFILL: if (pipe_last) state_nxt = IDLE;
            DWRITE:       if (wr_phase)  state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_was_d <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            issue_cnt  <= '0;
            wr_phase   <= 1'b0;
            vld_pipe   <= '0;
            last_pipe  <= '0;
        end else begin
            state <= state_nxt;
            if (accept_d || accept_i) begin
                addr_q     <= accept_d ? d_addr : i_addr;
                wdata_q    <= d_wdata;
                last_was_d <= accept_d;
                issue_cnt  <= '0;
            end else if (issuing) begin
                issue_cnt <= issue_cnt + CW'(1);
            end
            wr_phase     <= wr_cycle;
            vld_pipe[0]  <= issuing;
            last_pipe[0] <= issue_last;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    // Read data lands one cycle after issue; LATENCY-1 further stages follow.
    generate
        if (LATENCY > 1) begin : g_dpipe
            logic [15:0] data_pipe [LATENCY-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY - 1; i++) data_pipe[i] <= '0;
                end else begin
                    data_pipe[0] <= mem_rdata;
                    for (int i = 1; i < LATENCY - 1; i++) data_pipe[i] <= data_pipe[i-1];
                end
            end
            assign pipe_data = data_pipe[LATENCY-2];
        end else begin : g_nopipe
            assign pipe_data = mem_rdata;
        end
    endgenerate

    assign mem_en    = issuing | wr_cycle;
    assign mem_wr    = wr_cycle;
    assign mem_addr  = issuing  ? (addr_q & LINE_MASK) + 16'({issue_cnt, 1'b0}) :
                       wr_cycle ? {addr_q[15:1], 1'b0} : 16'h0000;
    assign mem_wdata = wr_cycle ? wdata_q : 16'h0000;

    assign fill_out     = pipe_vld ? pipe_data : 16'h0000;
    assign d_grant      = (state == DFILL) || (state == DWRITE);
    assign i_grant      = (state == IFILL);
    assign d_data_valid = (state == DFILL) && pipe_vld;
    assign i_data_valid = (state == IFILL) && pipe_vld;
    assign d_data       = (state == DFILL) ? fill_out : 16'h0000;
    assign i_data       = (state == IFILL) ? fill_out : 16'h0000;
    assign d_done       = ((state == DFILL) && pipe_last) || ((state == DWRITE) && wr_phase);
    assign i_done       = (state == IFILL) && pipe_last;
endmodule

// File: tb/tb_mem_fill_responder.sv
module tb_mem_fill_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rd_req = 1'b0, d_rd_req = 1'b0, d_wr_req = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        sel = 1'b0;   // 0: observe LATENCY=4 instance, 1: LATENCY=1

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance A (LATENCY=4) and B (LATENCY=1) share all inputs.
    logic        ig_a, iv_a, idn_a, dg_a, dv_a, ddn_a, me_a, mw_a;
    logic [15:0] id_a, dd_a, ma_a, mwd_a, mrd_a;
    logic        ig_b, iv_b, idn_b, dg_b, dv_b, ddn_b, me_b, mw_b;
    logic [15:0] id_b, dd_b, ma_b, mwd_b, mrd_b;

    mem_fill_responder #(.LATENCY(4), .WORDS(8)) dut_a (
        .clk(clk), .rst(rst),
        .i_rd_req(i_rd_req), .i_addr(i_addr), .i_grant(ig_a), .i_data(id_a),
        .i_data_valid(iv_a), .i_done(idn_a),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(dg_a), .d_data(dd_a), .d_data_valid(dv_a), .d_done(ddn_a),
        .mem_en(me_a), .mem_wr(mw_a), .mem_addr(ma_a), .mem_wdata(mwd_a), .mem_rdata(mrd_a));

    mem_fill_responder #(.LATENCY(1), .WORDS(8)) dut_b (
        .clk(clk), .rst(rst),
        .i_rd_req(i_rd_req), .i_addr(i_addr), .i_grant(ig_b), .i_data(id_b),
        .i_data_valid(iv_b), .i_done(idn_b),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(dg_b), .d_data(dd_b), .d_data_valid(dv_b), .d_done(ddn_b),
        .mem_en(me_b), .mem_wr(mw_b), .mem_addr(ma_b), .mem_wdata(mwd_b), .mem_rdata(mrd_b));

    function automatic logic [15:0] pat(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Backing store: registered read data, junk when no read was issued.
    always @(posedge clk) begin
        mrd_a <= (me_a && !mw_a) ? pat(ma_a) : 16'hDEAD;
        mrd_b <= (me_b && !mw_b) ? pat(ma_b) : 16'hDEAD;
    end

    wire        o_ig  = sel ? ig_b  : ig_a;
    wire        o_iv  = sel ? iv_b  : iv_a;
    wire        o_idn = sel ? idn_b : idn_a;
    wire [15:0] o_id  = sel ? id_b  : id_a;
    wire        o_dg  = sel ? dg_b  : dg_a;
    wire        o_dv  = sel ? dv_b  : dv_a;
    wire        o_ddn = sel ? ddn_b : ddn_a;
    wire [15:0] o_dd  = sel ? dd_b  : dd_a;
    wire        o_me  = sel ? me_b  : me_a;
    wire        o_mw  = sel ? mw_b  : mw_a;
    wire [15:0] o_ma  = sel ? ma_b  : ma_a;
    wire [15:0] o_mwd = sel ? mwd_b : mwd_a;
    wire [71:0] obs_all = {o_ig, o_id, o_iv, o_idn, o_dg, o_dd, o_dv, o_ddn,
                           o_me, o_mw, o_ma, o_mwd};

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        i_rd_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", obs_all, 0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          sel;
        bit          d_rd;
        bit          d_wr;
        bit          i_rd;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_addr;
    } vec_t;

    // One transaction: request held for a single edge, then req/addr/wdata
    // are scrambled to show that only the latched values matter.
    task automatic run_txn(input vec_t v);
        int  n_iss = 0, n_val = 0, n_wr = 0, wr_c = 0;
        int  iss_c [16];
        bit  done_seen = 0;
        bit  own_d = v.d_rd | v.d_wr;
        int  lat = v.sel ? 1 : 4;
        logic own_v, own_dn, oth_v;
        logic [15:0] own_dat, oth_dat;
        d_rd_req = v.d_rd; d_wr_req = v.d_wr; i_rd_req = v.i_rd;
        d_addr = v.addr; i_addr = v.addr; d_wdata = v.wdata;
        @(posedge clk); #1;
        d_rd_req = 1'b0; d_wr_req = 1'b0; i_rd_req = 1'b0;
        d_addr = ~v.addr; i_addr = ~v.addr; d_wdata = ~v.wdata;
        for (int c = 1; c <= 40 && !done_seen; c++) begin
            @(negedge clk);
            own_v   = own_d ? o_dv  : o_iv;
            own_dn  = own_d ? o_ddn : o_idn;
            own_dat = own_d ? o_dd  : o_id;
            oth_v   = own_d ? o_iv  : o_dv;
            oth_dat = own_d ? o_id  : o_dd;
            chk("grant", {o_dg, o_ig}, own_d ? 2'b10 : 2'b01);
            chk("other_side_quiet", {oth_v, oth_dat}, 0);
            if (o_me && !o_mw) begin
                chk("rd_addr", o_ma, v.exp_addr + 16'(2 * n_iss));
                if (n_iss < 16) iss_c[n_iss] = c;
                n_iss++;
            end
            if (o_me && o_mw) begin
                chk("wr_addr_data", {o_ma, o_mwd}, {v.exp_addr, v.wdata});
                wr_c = c;
                n_wr++;
            end
            if (!o_me) chk("mem_wr_idle", o_mw, 0);
            if (own_v) begin
                chk("fill_data", own_dat, pat(v.exp_addr + 16'(2 * n_val)));
                if (n_val < n_iss && n_val < 16) chk("fill_latency", c - iss_c[n_val], lat);
                else chk("valid_before_issue", n_val, n_iss);
                n_val++;
            end else begin
                chk("data_zero_when_invalid", own_dat, 0);
            end
            if (own_dn) begin
                done_seen = 1;
                chk("done_word_count", n_val, v.d_wr ? 0 : 8);
                chk("issue_count", n_iss, v.d_wr ? 0 : 8);
                chk("write_count", n_wr, v.d_wr ? 1 : 0);
                if (v.d_wr) chk("write_done_cycle", c, wr_c + 1);
                else chk("done_with_last_valid", own_v, 1);
            end
        end
        chk("done_seen", done_seen, 1);
        @(negedge clk);
        chk("idle_after_done", {o_dg, o_ig, o_me}, 0);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{0, 1, 0, 0, 16'h1236, 16'h0000, 16'h1230};
        vecs[1] = '{0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{0, 1, 1, 0, 16'h0041, 16'hBEEF, 16'h0040};
        vecs[3] = '{0, 0, 0, 1, 16'hFFF8, 16'h0000, 16'hFFF0};
        vecs[4] = '{0, 0, 1, 0, 16'h7FFF, 16'h1234, 16'h7FFE};
        vecs[5] = '{1, 0, 0, 1, 16'hFFF8, 16'h0000, 16'hFFF0};
        vecs[6] = '{1, 1, 0, 0, 16'hABCF, 16'h0000, 16'hABC0};

        @(negedge clk);
        apply_reset();
        for (int t = 0; t < 7; t++) begin
            sel = vecs[t].sel;
            run_txn(vecs[t]);
        end

        // Both caches request together and hold: D, I, D with one idle gap.
        begin
            logic [1:0] prev, cur;
            logic [1:0] order [3];
            int n_gr = 0, done_c = 0;
            sel = 1'b0;
            apply_reset();
            d_rd_req = 1'b1; i_rd_req = 1'b1; d_addr = 16'h0100; i_addr = 16'h0200;
            prev = 2'b00;
            for (int c = 1; c <= 120 && n_gr < 3; c++) begin
                @(negedge clk);
                cur = {o_dg, o_ig};
                chk("grant_exclusive", cur == 2'b11, 0);
                if (cur != 2'b00 && prev == 2'b00) begin
                    order[n_gr] = cur;
                    if (n_gr > 0) chk("idle_gap", c - done_c, 2);
                    n_gr++;
                end
                if (prev != 2'b00 && cur != 2'b00) chk("no_owner_switch", cur, prev);
                if (o_ddn || o_idn) done_c = c;
                prev = cur;
            end
            chk("arb_grant_count", n_gr, 3);
            if (n_gr == 3) chk("arb_order", {order[0], order[1], order[2]}, 6'b10_01_10);
            d_rd_req = 1'b0; i_rd_req = 1'b0;
        end

        // Reset at the 3rd data word of an I fill.
        begin
            int n_v = 0;
            bit hit = 0;
            apply_reset();
            i_rd_req = 1'b1; i_addr = 16'h0300;
            @(posedge clk); #1;
            i_rd_req = 1'b0;
            for (int c = 1; c <= 30 && !hit; c++) begin
                @(negedge clk);
                if (o_iv) n_v++;
                if (n_v == 3) begin
                    hit = 1;
                    rst = 1'b1;
                    #1;
                    chk("rst_mid_burst_outputs", obs_all, 0);
                end
            end
            chk("reached_third_word", hit, 1);
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                chk("no_stale_after_rst", {o_ig, o_iv, o_idn, o_me}, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
